// File: rtl/adc_pair_sampler_if.sv
// Signal bundle between the ADC pair sampler, the serial ADC it drives and the consumer
// of its paired samples. master = sampler side, slave = ADC/consumer side.
interface adc_pair_sampler_if;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_mosi;
    logic        adc_miso;
    logic        busy;
    logic        valid_out;
    logic [11:0] v_out;
    logic [11:0] i_out;

    modport master (
        output adc_cs_n, adc_sclk, adc_mosi, busy, valid_out, v_out, i_out,
        input  adc_miso
    );

    modport slave (
        input  adc_cs_n, adc_sclk, adc_mosi, busy, valid_out, v_out, i_out,
        output adc_miso
    );
endinterface

// File: rtl/adc_pair_sampler.sv
// SPI master for the dual-channel 12-bit ADC: converts voltage, then current, and publishes
// both as one ADC-format pair. Define ADC_SIGN_CLAMP_EN to publish negative results as zero.
module adc_pair_sampler #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 10,
    parameter logic [2:0]  V_CH    = 3'd0,
    parameter logic [2:0]  I_CH    = 3'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    adc_pair_sampler_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [15:0] V_WORD   = {2'b00, V_CH, 11'b0};
    localparam logic [15:0] I_WORD   = {2'b00, I_CH, 11'b0};

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_cnt;
    logic        is_i;
    logic [14:0] tx;
    logic [11:0] rx;
    logic [11:0] v_stage;

    logic        is_i_nxt;
    logic [15:0] nxt_word;

    function automatic logic [11:0] to_adc(input logic [11:0] raw);
`ifdef ADC_SIGN_CLAMP_EN
        if (raw[11]) return 12'h7FF;
`else
        if (raw[11]) return {1'b1, raw[10:0]};
`endif
        return {1'b0, raw[10:0] ^ 11'h7FF};
    endfunction

    // A V frame is always followed by an I frame; anything leaving IDLE starts a V frame.
    always_comb begin
        is_i_nxt = (state != IDLE) && !is_i;
        nxt_word = is_i_nxt ? I_WORD : V_WORD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            is_i          <= 1'b0;
            tx            <= '0;
            rx            <= '0;
            v_stage       <= 12'h7FF;
            bus.adc_cs_n  <= 1'b1;
            bus.adc_sclk  <= 1'b0;
            bus.adc_mosi  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.v_out     <= 12'h7FF;
            bus.i_out     <= 12'h7FF;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= SETUP;
                        cnt          <= '0;
                        is_i         <= is_i_nxt;
                        bus.adc_cs_n <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.adc_mosi <= nxt_word[15];
                        tx           <= nxt_word[14:0];
                    end
                end

                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        state        <= SHIFT;
                        cnt          <= '0;
                        bit_cnt      <= '0;
                        bus.adc_sclk <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else if (bus.adc_sclk) begin
                        // Only the low 12 bits are kept; the ignored upper nibble shifts out.
                        cnt          <= '0;
                        rx           <= {rx[10:0], bus.adc_miso};
                        bus.adc_sclk <= 1'b0;
                        bus.adc_mosi <= tx[14];
                        tx           <= {tx[13:0], 1'b0};
                    end else if (bit_cnt == 4'd15) begin
                        state        <= HOLD;
                        cnt          <= '0;
                        bus.adc_cs_n <= 1'b1;
                        bus.adc_mosi <= 1'b0;
                        if (is_i) begin
                            bus.v_out     <= v_stage;
                            bus.i_out     <= to_adc(rx);
                            bus.valid_out <= 1'b1;
                            bus.busy      <= 1'b0;
                        end else begin
                            v_stage <= to_adc(rx);
                        end
                    end else begin
                        cnt          <= '0;
                        bit_cnt      <= bit_cnt + 4'd1;
                        bus.adc_sclk <= 1'b1;
                    end
                end

                // HOLD is the first cs_n-high cycle; HOLD plus GAP together last GAP_CYC cycles.
                HOLD, GAP: begin
                    if (cnt != GAP_LAST) begin
                        state <= GAP;
                        cnt   <= cnt + 8'd1;
                    end else if (!is_i || enable) begin
                        state        <= SETUP;
                        cnt          <= '0;
                        is_i         <= is_i_nxt;
                        bus.adc_cs_n <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.adc_mosi <= nxt_word[15];
                        tx           <= nxt_word[14:0];
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_pair_sampler.sv
// Directed bench for adc_pair_sampler: ADC model on the SPI pins plus a pair-level
// scoreboard that checks every cycle.
`timescale 1ns/1ps
module tb_adc_pair_sampler;
    localparam int CLK_DIV  = 2;
    localparam int GAP_CYC  = 10;
    localparam int FRAME_LO = 33 * CLK_DIV;
    localparam int PAIR     = 2 * (FRAME_LO + GAP_CYC);

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;

    adc_pair_sampler_if bus();

    adc_pair_sampler #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .V_CH(3'd0), .I_CH(3'd1)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_falls     = 0;
    int n_valid     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC-format value a raw two's-complement code must publish as.
    function automatic logic [11:0] model_adc(input logic [11:0] raw);
        if (raw < 12'h800) return 12'h7FF - raw;
`ifdef ADC_SIGN_CLAMP_EN
        return 12'h7FF;
`else
        return raw;
`endif
    endfunction

    // ADC model: frames alternate V, I from reset; result driven on each sclk rise.
    logic [11:0] raw_v = 12'h000, raw_i = 12'h000;
    logic [11:0] served_v = 12'h000, served_i = 12'h000;
    logic [15:0] resp = 16'h0, mosi_word = 16'h0;
    logic        frame_is_i = 1'b0, next_is_i = 1'b0;
    int          bit_k = 0;

    always @(negedge bus.adc_cs_n or posedge bus.adc_sclk or negedge reset) begin
        if (!reset) begin
            next_is_i    = 1'b0;
            bit_k        = 0;
            bus.adc_miso = 1'b0;
        end else if (bus.adc_sclk) begin
            mosi_word    = {mosi_word[14:0], bus.adc_mosi};
            bus.adc_miso = resp[15 - bit_k];
            bit_k++;
        end else begin
            frame_is_i = next_is_i;
            next_is_i  = !next_is_i;
            bit_k      = 0;
            mosi_word  = 16'h0;
            if (frame_is_i) begin served_i = raw_i; resp = {4'hA, raw_i}; end
            else            begin served_v = raw_v; resp = {4'h5, raw_v}; end
            bus.adc_miso = 1'b0;
        end
    end

    // Scoreboard: published pair, busy and frame timing derived from cs_n activity.
    logic [11:0] pub_v = 12'h7FF, pub_i = 12'h7FF;
    logic        prev_cs = 1'b1, in_pair = 1'b0;
    int          lo_run = 0, hi_run = 0;

    always @(negedge clk) begin : mon
        logic exp_valid;
        if (!reset) begin
            pub_v   = 12'h7FF;
            pub_i   = 12'h7FF;
            prev_cs = 1'b1;
            in_pair = 1'b0;
            lo_run  = 0;
            hi_run  = 0;
        end else begin
            exp_valid = bus.adc_cs_n && !prev_cs && frame_is_i;
            if (!bus.adc_cs_n && prev_cs) begin
                if (frame_is_i) chk("gap_cycles", hi_run, GAP_CYC);
                else            in_pair = 1'b1;
                n_falls++;
                hi_run = 0;
            end
            if (bus.adc_cs_n && !prev_cs) begin
                chk("cs_low_cycles", lo_run, FRAME_LO);
                chk("mosi_word", mosi_word, {2'b00, (frame_is_i ? 3'd1 : 3'd0), 11'b0});
                lo_run = 0;
            end
            if (exp_valid) begin
                pub_v   = model_adc(served_v);
                pub_i   = model_adc(served_i);
                in_pair = 1'b0;
            end
            if (bus.valid_out) n_valid++;
            chk("valid_out", bus.valid_out, exp_valid);
            chk("busy", bus.busy, in_pair);
            chk("v_out", bus.v_out, pub_v);
            chk("i_out", bus.i_out, pub_i);
            if (bus.adc_cs_n) begin
                chk("sclk_idle_low", bus.adc_sclk, 1'b0);
                hi_run++;
            end else begin
                lo_run++;
            end
            prev_cs = bus.adc_cs_n;
        end
    end

    task automatic wait_valid(input string name, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                t = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no valid_out within 400 cycles", name);
    endtask

    task automatic wait_cs(input logic level, input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.adc_cs_n == level) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: cs_n did not reach %0d within 400 cycles", name, level);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t1, t2, nv, nf;
        raw_v = 12'h100;
        raw_i = 12'h020;

        // Reset values, then a long enabled-low idle window
        repeat (3) @(negedge clk);
        chk("rst_cs_n", bus.adc_cs_n, 1'b1);
        chk("rst_sclk", bus.adc_sclk, 1'b0);
        chk("rst_mosi", bus.adc_mosi, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.valid_out, 1'b0);
        chk("rst_v_out", bus.v_out, 12'h7FF);
        chk("rst_i_out", bus.i_out, 12'h7FF);
        reset = 1'b1;
        nv = n_valid;
        nf = n_falls;
        repeat (500) @(negedge clk);
        chk("idle_cs_falls", n_falls - nf, 0);
        chk("idle_valids", n_valid - nv, 0);
        chk("idle_cs_n", bus.adc_cs_n, 1'b1);
        chk("idle_v_out", bus.v_out, 12'h7FF);

        // Back-to-back pairs with raw 0x100 / 0x020
        enable = 1'b1;
        @(negedge clk);
        chk("enable_to_cs_fall", bus.adc_cs_n, 1'b0);
        wait_cs(1'b1, "v_frame_end");
        chk("v_mosi_literal", mosi_word, 16'h0000);
        wait_valid("pair1", t1);
        chk("i_mosi_literal", mosi_word, 16'h0800);
        chk("pair1_v_literal", bus.v_out, 12'h6FF);
        chk("pair1_i_literal", bus.i_out, 12'h7DF);
        chk("pair1_busy_low", bus.busy, 1'b0);
        wait_valid("pair2", t2);
        chk("pair_period", t2 - t1, PAIR);
        chk("pair_period_literal", t2 - t1, 152);

        // Full-scale positive and zero
        raw_v = 12'h7FF;
        raw_i = 12'h000;
        wait_valid("pair_fullscale", t1);
        chk("fullscale_v_literal", bus.v_out, 12'h000);
        chk("fullscale_i_literal", bus.i_out, 12'h7FF);

        // Negative codes
        raw_v = 12'hF00;
        raw_i = 12'h800;
        wait_valid("pair_negative", t1);
`ifdef ADC_SIGN_CLAMP_EN
        chk("neg_v_literal", bus.v_out, 12'h7FF);
        chk("neg_i_literal", bus.i_out, 12'h7FF);
`else
        chk("neg_v_literal", bus.v_out, 12'hF00);
        chk("neg_i_literal", bus.i_out, 12'h800);
`endif

        // Drop enable 5 cycles into a V frame: the pair still completes, then idle
        wait_cs(1'b0, "drop_v_start");
        repeat (5) @(negedge clk);
        enable = 1'b0;
        nv = n_valid;
        wait_valid("drop_pair", t1);
        nf = n_falls;
        repeat (300) @(negedge clk);
        chk("drop_no_new_frame", n_falls - nf, 0);
        chk("drop_one_valid", n_valid - nv, 1);
        chk("drop_idle_cs_n", bus.adc_cs_n, 1'b1);

        // Reset 20 cycles into an I frame
        raw_v = 12'h7FE;
        raw_i = 12'h001;
        enable = 1'b1;
        wait_cs(1'b0, "rst_v_start");
        wait_cs(1'b1, "rst_v_end");
        wait_cs(1'b0, "rst_i_start");
        repeat (20) @(negedge clk);
        nv = n_valid;
        #2 reset = 1'b0;
        #1;
        chk("midrst_cs_n", bus.adc_cs_n, 1'b1);
        chk("midrst_sclk", bus.adc_sclk, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_valid", bus.valid_out, 1'b0);
        chk("midrst_v_out", bus.v_out, 12'h7FF);
        chk("midrst_i_out", bus.i_out, 12'h7FF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_cs_fall", bus.adc_cs_n, 1'b0);
        chk("rel_fresh_v_frame", frame_is_i, 1'b0);
        chk("rel_no_valid", n_valid - nv, 0);
        wait_cs(1'b1, "rel_v_end");
        chk("rel_v_mosi_literal", mosi_word, 16'h0000);
        wait_valid("rel_pair", t1);
        chk("rel_v_literal", bus.v_out, 12'h001);
        chk("rel_i_literal", bus.i_out, 12'h7FE);
        enable = 1'b0;
        repeat (200) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
